// File: rtl/sourceout_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sourceout_pkg
//  Purpose  : Shared types and constants for the multi-channel source-out
//             scheduler (state encoding, length scaling, default threshold).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package sourceout_pkg;

    // Lengths are programmed in 4-word units.
    localparam int LEN_SHIFT       = 2;
    // A channel arms once its registered used-words exceeds this level.
    localparam int DEF_START_LEVEL = 5000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        LOAD  = 3'd2,
        BURST = 3'd3,
        GAP   = 3'd4
    } state_e;

    // Scale a programmed length to words; the top LEN_SHIFT bits fall off.
    function automatic logic [31:0] len_words(input logic [31:0] len);
        return len << LEN_SHIFT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sourceout_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : sourceout_rr_arb
//  Purpose  : Combinational round-robin pick. Returns the first eligible
//             channel found searching upward from i_rr_ptr with wrap.
//  Ports    : i_eligible  per-channel eligibility vector
//             i_rr_ptr    search start index (< NCH)
//             o_grant     selected channel index
//             o_found     high when any channel is eligible
//  Revision : 1.0  initial release
// ============================================================================
module sourceout_rr_arb #(
    parameter int NCH   = 4,
    parameter int PTR_W = $clog2(NCH)
) (
    input  logic [NCH-1:0]   i_eligible,
    input  logic [PTR_W-1:0] i_rr_ptr,
    output logic [PTR_W-1:0] o_grant,
    output logic             o_found
);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            // Modulo-NCH offset without a divider; NCH need not be a power of 2.
            w_sum = {1'b0, i_rr_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(NCH)) begin
                w_sum = w_sum - (PTR_W+1)'(NCH);
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!o_found && i_eligible[w_idx]) begin
                o_found = 1'b1;
                o_grant = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sourceout_sched.sv
`default_nettype none
// ============================================================================
//  Module   : sourceout_sched
//  Purpose  : Shares one downstream output path between NCH source FIFOs.
//             A channel arms once its FIFO fill passes START_LEVEL, then is
//             granted round-robin a burst of reads followed by an idle gap.
//  Ports    : clk, RST (async, active-high)
//             enable        scheduler run enable
//             data_length   NCH x 32 burst length, 4-word units
//             blank_length  NCH x 32 gap length, 4-word units
//             fifo_usedw    NCH x USEDW_W FIFO read-side used words
//             uflow_clr     pulse, clears sticky underflow flags
//             fifo_rden     one-hot FIFO read enable (registered)
//             ch_sel        granted channel while a read is issued
//             data_valid    read enable delayed by the FIFO read latency
//             valid_ch      ch_sel aligned with data_valid
//             uflow         sticky per-channel underflow flags
//             busy          scheduler not in IDLE
//  Options  : SOURCEOUT_UFLOW_EN - abort bursts on empty FIFO, flag sticky
//             underflow and disarm the channel. Undefined: uflow reads 0.
//  Revision : 1.0  initial release
// ============================================================================
module sourceout_sched
    import sourceout_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int USEDW_W     = 15,
    parameter int START_LEVEL = DEF_START_LEVEL
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     enable,
    input  logic [NCH*32-1:0]        data_length,
    input  logic [NCH*32-1:0]        blank_length,
    input  logic [NCH*USEDW_W-1:0]   fifo_usedw,
    input  logic                     uflow_clr,
    output logic [NCH-1:0]           fifo_rden,
    output logic [$clog2(NCH)-1:0]   ch_sel,
    output logic                     data_valid,
    output logic [$clog2(NCH)-1:0]   valid_ch,
    output logic [NCH-1:0]           uflow,
    output logic                     busy
);

    localparam int                   PTR_W         = $clog2(NCH);
    localparam logic [USEDW_W-1:0]   c_START_LEVEL = USEDW_W'(START_LEVEL);

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       grant_q, grant_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [31:0]            pos_q, pos_d;
    logic [31:0]            neg_q, neg_d;
    logic [31:0]            count_q, count_d;
    logic [NCH-1:0]         armed_q, armed_d;
    logic [NCH-1:0]         rden_q, rden_d;
    logic [NCH-1:0]         uflow_q, uflow_d;
    logic [PTR_W-1:0]       ch_sel_q, ch_sel_d;
    logic [PTR_W-1:0]       valid_ch_q;
    logic                   data_valid_q;
    logic [USEDW_W-1:0]     usedw_q [NCH];

    logic [31:0]            w_pos_len [NCH];
    logic [31:0]            w_neg_len [NCH];
    logic [NCH-1:0]         w_above;
    logic [NCH-1:0]         w_eligible;
    logic [NCH-1:0]         w_uflow_set;
    logic [NCH-1:0]         w_grant_onehot;
    logic [PTR_W-1:0]       w_arb_grant;
    logic                   w_arb_found;
    logic [PTR_W-1:0]       w_next_ptr;
    logic                   w_empty;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_chan
            assign w_pos_len[i]  = len_words(data_length[32*i +: 32]);
            assign w_neg_len[i]  = len_words(blank_length[32*i +: 32]);
            assign w_above[i]    = usedw_q[i] > c_START_LEVEL;
            assign w_eligible[i] = armed_q[i] && (w_pos_len[i] != 32'd0);
        end
    endgenerate

    sourceout_rr_arb #(
        .NCH   (NCH),
        .PTR_W (PTR_W)
    ) u_arb (
        .i_eligible (w_eligible),
        .i_rr_ptr   (rr_ptr_q),
        .o_grant    (w_arb_grant),
        .o_found    (w_arb_found)
    );

    assign w_grant_onehot = NCH'(1) << grant_q;
    assign w_next_ptr     = (grant_q == PTR_W'(NCH-1)) ? '0 : grant_q + 1'b1;

`ifdef SOURCEOUT_UFLOW_EN
    // Registered fill is one cycle stale, so up to two reads may hit an
    // already-empty FIFO before the abort takes effect.
    assign w_empty = (usedw_q[grant_q] == '0);
`else
    assign w_empty = 1'b0;
    logic w_unused_uflow_clr;
    assign w_unused_uflow_clr = uflow_clr;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        pos_d       = pos_q;
        neg_d       = neg_q;
        count_d     = count_q;
        rden_d      = '0;
        ch_sel_d    = '0;
        w_uflow_set = '0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (w_arb_found) begin
                    grant_d = w_arb_grant;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Lengths are frozen here; later input changes wait for the next grant.
                pos_d   = w_pos_len[grant_q];
                neg_d   = w_neg_len[grant_q];
                count_d = '0;
                if (w_pos_len[grant_q] == 32'd0) begin
                    // Length went to zero after arbitration; drop the grant.
                    state_d = ARB;
                end else begin
                    state_d  = BURST;
                    rden_d   = w_grant_onehot;
                    ch_sel_d = grant_q;
                end
            end
            BURST: begin
                if (w_empty) begin
                    w_uflow_set = w_grant_onehot;
                    rr_ptr_d    = w_next_ptr;
                    count_d     = '0;
                    state_d     = ARB;
                end else if (count_q == pos_q - 32'd1) begin
                    rr_ptr_d = w_next_ptr;
                    count_d  = '0;
                    state_d  = (neg_q != 32'd0) ? GAP : ARB;
                end else begin
                    count_d  = count_q + 32'd1;
                    rden_d   = w_grant_onehot;
                    ch_sel_d = grant_q;
                end
            end
            GAP: begin
                if (count_q == neg_q - 32'd1) begin
                    count_d = '0;
                    state_d = ARB;
                end else begin
                    count_d = count_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        armed_d = (armed_q | w_above) & ~w_uflow_set;
`ifdef SOURCEOUT_UFLOW_EN
        // A new underflow beats a simultaneous clear.
        uflow_d = (uflow_q & ~{NCH{uflow_clr}}) | w_uflow_set;
`else
        uflow_d = '0;
`endif
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            pos_q        <= '0;
            neg_q        <= '0;
            count_q      <= '0;
            armed_q      <= '0;
            rden_q       <= '0;
            uflow_q      <= '0;
            ch_sel_q     <= '0;
            valid_ch_q   <= '0;
            data_valid_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                usedw_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            pos_q        <= pos_d;
            neg_q        <= neg_d;
            count_q      <= count_d;
            armed_q      <= armed_d;
            rden_q       <= rden_d;
            uflow_q      <= uflow_d;
            ch_sel_q     <= ch_sel_d;
            valid_ch_q   <= ch_sel_q;
            data_valid_q <= |rden_q;
            for (int i = 0; i < NCH; i++) begin
                usedw_q[i] <= fifo_usedw[USEDW_W*i +: USEDW_W];
            end
        end
    end

    assign fifo_rden  = rden_q;
    assign ch_sel     = ch_sel_q;
    assign data_valid = data_valid_q;
    assign valid_ch   = valid_ch_q;
    assign uflow      = uflow_q;
    assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sourceout_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sourceout_sched
//  Purpose  : Self-checking bench for sourceout_sched. Expected read
//             schedules come from a grant-by-grant timeline model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sourceout_sched;

    localparam int NCH = 4;
    localparam int UW  = 15;
    localparam int S   = 64;

    logic                 clk = 1'b0;
    logic                 RST;
    logic                 enable;
    logic                 uflow_clr;
    logic [NCH*32-1:0]    data_length;
    logic [NCH*32-1:0]    blank_length;
    logic [NCH*UW-1:0]    fifo_usedw;
    logic [NCH-1:0]       fifo_rden;
    logic [1:0]           ch_sel;
    logic                 data_valid;
    logic [1:0]           valid_ch;
    logic [NCH-1:0]       uflow;
    logic                 busy;

    int         n_pass = 0;
    int         n_chk  = 0;
    int         cfg_usedw [NCH];
    int         cfg_dl    [NCH];
    int         cfg_bl    [NCH];
    int         exp_ch    [S];
    logic [1:0] junk;

    always #5 clk = ~clk;

    sourceout_sched #(
        .NCH         (NCH),
        .USEDW_W     (UW),
        .START_LEVEL (5000)
    ) dut (
        .clk          (clk),
        .RST          (RST),
        .enable       (enable),
        .data_length  (data_length),
        .blank_length (blank_length),
        .fifo_usedw   (fifo_usedw),
        .uflow_clr    (uflow_clr),
        .fifo_rden    (fifo_rden),
        .ch_sel       (ch_sel),
        .data_valid   (data_valid),
        .valid_ch     (valid_ch),
        .uflow        (uflow),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < NCH; i++) begin
            fifo_usedw[i*UW +: UW]    = UW'(cfg_usedw[i]);
            data_length[i*32 +: 32]   = {junk, 30'(cfg_dl[i])};
            blank_length[i*32 +: 32]  = {~junk, 30'(cfg_bl[i])};
        end
    endtask

    task automatic set_single(input int ch, input int dl, input int bl);
        for (int i = 0; i < NCH; i++) begin
            cfg_usedw[i] = 0;
            cfg_dl[i]    = 1;
            cfg_bl[i]    = 0;
        end
        cfg_usedw[ch] = 6000;
        cfg_dl[ch]    = dl;
        cfg_bl[ch]    = bl;
    endtask

    // Reset, apply config, release, wait long enough for channels to arm.
    task automatic do_reset(input string name);
        RST       = 1'b1;
        enable    = 1'b0;
        uflow_clr = 1'b0;
        apply_cfg();
        repeat (2) @(negedge clk);
        chk({name, "_rst_rden"},  fifo_rden,  0);
        chk({name, "_rst_dv"},    data_valid, 0);
        chk({name, "_rst_busy"},  busy,       0);
        chk({name, "_rst_uflow"}, uflow,      0);
        chk({name, "_rst_chsel"}, ch_sel,     0);
        RST = 1'b0;
        repeat (3) @(negedge clk);
        chk({name, "_idle_rden"}, fifo_rden, 0);
        chk({name, "_idle_busy"}, busy,      0);
    endtask

    // Timeline model: each grant costs ARB+LOAD, then pos reads, then neg idle.
    task automatic build_model();
        int t   = 0;
        int ptr = 0;
        int ch;
        for (int s = 0; s < S; s++) exp_ch[s] = -1;
        while (t < S) begin
            ch = -1;
            for (int k = 0; k < NCH; k++) begin
                int c = (ptr + k) % NCH;
                if (ch < 0 && cfg_usedw[c] > 5000 && cfg_dl[c] != 0) ch = c;
            end
            if (ch < 0) break;
            for (int k = 0; k < 4 * cfg_dl[ch]; k++)
                if (t + 2 + k < S) exp_ch[t + 2 + k] = ch;
            t   = t + 2 + 4 * cfg_dl[ch] + 4 * cfg_bl[ch];
            ptr = (ch + 1) % NCH;
        end
    endtask

    task automatic run_sched(input string name);
        int prev = -1;
        build_model();
        enable = 1'b1;
        for (int s = 0; s < S; s++) begin
            @(negedge clk);
            chk($sformatf("%s_rden_s%0d", name, s), fifo_rden,
                (exp_ch[s] >= 0) ? (32'd1 << exp_ch[s]) : 32'd0);
            if (exp_ch[s] >= 0)
                chk($sformatf("%s_chsel_s%0d", name, s), ch_sel, exp_ch[s]);
            chk($sformatf("%s_dv_s%0d", name, s), data_valid, (prev >= 0) ? 1 : 0);
            if (prev >= 0)
                chk($sformatf("%s_vch_s%0d", name, s), valid_ch, prev);
            chk($sformatf("%s_busy_s%0d", name, s), busy, 1);
            prev = exp_ch[s];
        end
        enable = 1'b0;
    endtask

    initial begin
        RST = 1'b1; enable = 1'b0; uflow_clr = 1'b0; junk = 2'b00;
        data_length = '0; blank_length = '0; fifo_usedw = '0;

        // Single channel, 8 reads then 4 gap + 2 dead cycles.
        set_single(0, 2, 1);
        do_reset("single");
        run_sched("single");

        // Channels 0 and 2 alternate; 1 and 3 stay below threshold.
        set_single(0, 1, 0);
        cfg_usedw[2] = 7000; cfg_dl[2] = 1;
        cfg_usedw[1] = 100;  cfg_usedw[3] = 4000;
        do_reset("alt02");
        run_sched("alt02");

        // Zero data length skipped, zero blank has no gap, usedw=5000 not armed.
        junk = 2'b11;
        set_single(1, 1, 0);
        cfg_usedw[0] = 6000; cfg_dl[0] = 0; cfg_bl[0] = 1;
        cfg_usedw[2] = 6000; cfg_dl[2] = 2; cfg_bl[2] = 0;
        cfg_usedw[3] = 5000; cfg_dl[3] = 1;
        do_reset("zero");
        run_sched("zero");

        // Randomized configurations.
        for (int r = 0; r < 6; r++) begin
            junk = 2'($urandom);
            for (int i = 0; i < NCH; i++) begin
                cfg_usedw[i] = ($urandom % 2 != 0) ? 5001 + int'($urandom % 2000)
                                                   : int'($urandom % 5001);
                cfg_dl[i] = int'($urandom % 3);
                cfg_bl[i] = int'($urandom % 3);
            end
            begin
                int c = int'($urandom % NCH);
                cfg_usedw[c] = 6000;
                if (cfg_dl[c] == 0) cfg_dl[c] = 1;
            end
            do_reset($sformatf("rnd%0d", r));
            run_sched($sformatf("rnd%0d", r));
        end

        // Enable dropped mid-burst; lengths changed mid-burst are ignored.
        junk = 2'b00;
        set_single(0, 2, 1);
        do_reset("endrop");
        enable = 1'b1;
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            chk($sformatf("endrop_rden_s%0d", s), fifo_rden, (s >= 2 && s <= 9) ? 1 : 0);
            chk($sformatf("endrop_busy_s%0d", s), busy, (s <= 14) ? 1 : 0);
            if (s == 4) begin
                enable = 1'b0;
                cfg_dl[0] = 5; cfg_bl[0] = 3;
                apply_cfg();
            end
        end

        // Asynchronous reset mid-burst, then re-arm before any read.
        set_single(0, 2, 1);
        do_reset("arst");
        enable = 1'b1;
        repeat (5) @(negedge clk);
        chk("arst_pre_rden", fifo_rden, 1);
        #2 RST = 1'b1;
        #1;
        chk("arst_rden",  fifo_rden,  0);
        chk("arst_dv",    data_valid, 0);
        chk("arst_busy",  busy,       0);
        chk("arst_uflow", uflow,      0);
        @(negedge clk);
        RST = 1'b0;
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            chk($sformatf("arst_rearm_rden_r%0d", r), fifo_rden, (r >= 3) ? 1 : 0);
        end
        enable = 1'b0;

        // Channel 1 FIFO empties mid-burst; clear pulse coincides with the set.
        set_single(1, 4, 0);
        do_reset("uf");
        enable = 1'b1;
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
`ifdef SOURCEOUT_UFLOW_EN
            chk($sformatf("uf_rden_s%0d", s), fifo_rden, (s >= 2 && s <= 6) ? 2 : 0);
            chk($sformatf("uf_flag_s%0d", s), uflow, (s >= 7) ? 2 : 0);
`else
            chk($sformatf("uf_rden_s%0d", s), fifo_rden, (s >= 2 && s <= 17) ? 2 : 0);
            chk($sformatf("uf_flag_s%0d", s), uflow, 0);
`endif
            if (s == 5) begin
                cfg_usedw[1] = 0;
                apply_cfg();
            end
            uflow_clr = (s == 6);
        end
`ifdef SOURCEOUT_UFLOW_EN
        cfg_usedw[1] = 6000;
        apply_cfg();
        uflow_clr = 1'b1;
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            uflow_clr = 1'b0;
            chk($sformatf("uf_clr_flag_r%0d", r), uflow, 0);
            chk($sformatf("uf_rearm_rden_r%0d", r), fifo_rden, (r >= 3) ? 2 : 0);
        end
`endif
        enable = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
